cond_unit_ex: RTL and testbench

- Execute-stage conditional-execution unit of the pipelined ARMv3 core.
- Owns the architectural NZCV flags register.
- Evaluates each instruction's 4-bit condition field against the committed flags and updates the flags from the ALU result when permitted.
- Gates the write-type control signals and registers them into the EX/MEM pipeline register.
- Keeps a saturating count of condition-failed (annulled) instructions for performance debug.

---
 rtl/cond_pkg.sv | 32 +++
 rtl/cond_unit_ex_if.sv | 36 +++
 rtl/cond_eval.sv | 38 +++
 rtl/cond_unit_ex.sv | 82 ++++++++
 tb/tb_cond_unit_ex.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared constants for ARM condition evaluation and NZCV flag handling,
// used by the execute-stage condition unit and the decode-stage predictor.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_unit_ex_if.sv
// Execute-stage control bundle between the pipeline (master) and the
// conditional-execution unit (slave).
interface cond_unit_ex_if #(
    parameter int CNT_W = 16
);
    logic             valid_e;
    logic             stall_e;
    logic             flush_e;
    logic [3:0]       cond_e;
    logic [1:0]       flag_w_e;
    logic [3:0]       alu_flags;
    logic             reg_w_e;
    logic             mem_w_e;
    logic             pcs_e;
    logic             no_write_e;
    logic             cnt_clr;
    logic [3:0]       flags;
    logic             cond_ex_e;
    logic             reg_write_m;
    logic             mem_write_m;
    logic             pc_src_m;
    logic [CNT_W-1:0] annul_cnt;

    // No handshake: the execute stage advances whenever stall_e and flush_e are both low.
    modport master (
        output valid_e, stall_e, flush_e, cond_e, flag_w_e, alu_flags,
               reg_w_e, mem_w_e, pcs_e, no_write_e, cnt_clr,
        input  flags, cond_ex_e, reg_write_m, mem_write_m, pc_src_m, annul_cnt
    );

    modport slave (
        input  valid_e, stall_e, flush_e, cond_e, flag_w_e, alu_flags,
               reg_w_e, mem_w_e, pcs_e, no_write_e, cnt_clr,
        output flags, cond_ex_e, reg_write_m, mem_write_m, pc_src_m, annul_cnt
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-field evaluator: (cond, NZCV) -> pass.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_unit_ex.sv
// Execute-stage conditional-execution unit: owns NZCV, gates write controls
// into EX/MEM, and counts annulled instructions.
module cond_unit_ex
    import cond_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input logic          clk,
    input logic          rst_n,
    cond_unit_ex_if.slave ex
);
    logic [3:0]       flags_q;
    logic [3:0]       flags_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             pass;
    logic             adv;
    logic             cond_ex;
    logic             annul;
    logic             reg_write_q;
    logic             mem_write_q;
    logic             pc_src_q;

    cond_eval u_cond_eval (
        .cond  (ex.cond_e),
        .flags (flags_q),
        .pass  (pass)
    );

    // Flush dominates stall: either one turns this slot into a bubble.
    assign adv     = !ex.stall_e && !ex.flush_e;
    assign cond_ex = ex.valid_e && !ex.flush_e && pass;
    assign annul   = adv && ex.valid_e && !pass;

    always_comb begin
        flags_nxt = flags_q;
        if (adv && cond_ex) begin
            if ((ex.flag_w_e & FW_NZ) != FW_NONE) begin
                flags_nxt[FLAG_N] = ex.alu_flags[FLAG_N];
                flags_nxt[FLAG_Z] = ex.alu_flags[FLAG_Z];
            end
            if ((ex.flag_w_e & FW_CV) != FW_NONE) begin
                flags_nxt[FLAG_C] = ex.alu_flags[FLAG_C];
                flags_nxt[FLAG_V] = ex.alu_flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q     <= FLAGS_RST;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            flags_q <= flags_nxt;
            if (adv) begin
                reg_write_q <= cond_ex && ex.reg_w_e && !ex.no_write_e;
                mem_write_q <= cond_ex && ex.mem_w_e;
                pc_src_q    <= cond_ex && ex.pcs_e;
            end else begin
                reg_write_q <= 1'b0;
                mem_write_q <= 1'b0;
                pc_src_q    <= 1'b0;
            end
            // Clear beats a simultaneous increment; the count sticks at all-ones.
            if (ex.cnt_clr) begin
                cnt_q <= '0;
            end else if (annul && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ex.flags       = flags_q;
    assign ex.cond_ex_e   = cond_ex;
    assign ex.reg_write_m = reg_write_q;
    assign ex.mem_write_m = mem_write_q;
    assign ex.pc_src_m    = pc_src_q;
    assign ex.annul_cnt   = cnt_q;
endmodule

// File: tb/tb_cond_unit_ex.sv
// Directed scoreboard bench for cond_unit_ex: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_cond_unit_ex;
    import cond_pkg::*;

    localparam int CNT_W = 16;
    localparam int RW    = 4 + 3 + CNT_W;

    logic clk;
    logic rst_n;

    cond_unit_ex_if #(.CNT_W(CNT_W)) ex_if ();

    cond_unit_ex #(.CNT_W(CNT_W), .FLAGS_RST(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (ex_if.slave)
    );

    // Clock and reset-level defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:0]    comb_q[$];
    logic [RW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;
    logic          reg_pending;
    logic [RW-1:0] reg_exp;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reg_pending = 1'b0;
        reg_exp     = '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: registered results from the previous slot, then cond_ex_e of the current one.
    always @(negedge clk) begin
        if (reg_pending) begin
            check("flags",       {28'd0, ex_if.flags},       {28'd0, reg_exp[RW-1 -: 4]});
            check("reg_write_m", {31'd0, ex_if.reg_write_m}, {31'd0, reg_exp[CNT_W+2]});
            check("mem_write_m", {31'd0, ex_if.mem_write_m}, {31'd0, reg_exp[CNT_W+1]});
            check("pc_src_m",    {31'd0, ex_if.pc_src_m},    {31'd0, reg_exp[CNT_W]});
            check("annul_cnt",   {16'd0, ex_if.annul_cnt},   {16'd0, reg_exp[CNT_W-1:0]});
            reg_pending = 1'b0;
        end
        if (comb_q.size() > 0) begin
            logic [0:0] c;
            c = comb_q.pop_front();
            check("cond_ex_e", {31'd0, ex_if.cond_ex_e}, {31'd0, c});
            reg_exp     = exp_q.pop_front();
            reg_pending = 1'b1;
        end
    end

    // Driver: one slot per call, inputs applied just after the rising edge.
    task automatic issue(
        input logic rst, input logic valid, input logic stall, input logic flush,
        input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
        input logic rw, input logic mw, input logic pcs, input logic nw, input logic clr,
        input logic e_cond, input logic [3:0] e_flags, input logic e_rw,
        input logic e_mw, input logic e_pc, input logic [CNT_W-1:0] e_cnt
    );
        @(posedge clk);
        #1;
        rst_n               = !rst;
        ex_if.valid_e       = valid;
        ex_if.stall_e       = stall;
        ex_if.flush_e       = flush;
        ex_if.cond_e        = cond;
        ex_if.flag_w_e      = fw;
        ex_if.alu_flags     = alu;
        ex_if.reg_w_e       = rw;
        ex_if.mem_w_e       = mw;
        ex_if.pcs_e         = pcs;
        ex_if.no_write_e    = nw;
        ex_if.cnt_clr       = clr;
        comb_q.push_back(e_cond);
        exp_q.push_back({e_flags, e_rw, e_mw, e_pc, e_cnt});
    endtask

    initial begin
        rst_n = 1'b0;
        ex_if.valid_e = 0; ex_if.stall_e = 0; ex_if.flush_e = 0; ex_if.cond_e = COND_AL;
        ex_if.flag_w_e = FW_NONE; ex_if.alu_flags = 0; ex_if.reg_w_e = 0; ex_if.mem_w_e = 0;
        ex_if.pcs_e = 0; ex_if.no_write_e = 0; ex_if.cnt_clr = 0;

        // rst valid stall flush cond    fw      alu      rw mw pc nw clr | cond flags rw mw pc cnt
        issue(1, 0, 0, 0, COND_AL, FW_NONE, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0, 0);
        issue(1, 0, 0, 0, COND_AL, FW_NONE, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0, 0);
        // CMP setting Z
        issue(0, 1, 0, 0, COND_AL, FW_ALL,  4'b0100, 1, 0, 0, 1, 0,   1, 4'b0100, 0, 0, 0, 0);
        issue(0, 1, 0, 0, COND_EQ, FW_NONE, 4'b1111, 1, 0, 0, 0, 0,   1, 4'b0100, 1, 0, 0, 0);
        issue(0, 1, 0, 0, COND_NE, FW_NONE, 4'b1111, 1, 0, 0, 0, 0,   0, 4'b0100, 0, 0, 0, 1);
        issue(0, 1, 0, 0, COND_AL, FW_ALL,  4'b0000, 0, 0, 0, 0, 0,   1, 4'b0000, 0, 0, 0, 1);
        // Conditional ADDS MI with N clear: annulled, flags untouched
        issue(0, 1, 0, 0, COND_MI, FW_ALL,  4'b1000, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0, 0, 2);
        // Stall holds, release applies
        issue(0, 1, 1, 0, COND_AL, FW_ALL,  4'b0011, 1, 0, 0, 0, 0,   1, 4'b0000, 0, 0, 0, 2);
        issue(0, 1, 0, 0, COND_AL, FW_ALL,  4'b0011, 1, 0, 0, 0, 0,   1, 4'b0011, 1, 0, 0, 2);
        // Flush+stall on failing EQ, then flush alone on AL: bubbles, no side effects
        issue(0, 1, 1, 1, COND_EQ, FW_ALL,  4'b1111, 1, 1, 1, 0, 0,   0, 4'b0011, 0, 0, 0, 2);
        issue(0, 1, 0, 1, COND_AL, FW_ALL,  4'b1111, 1, 1, 1, 0, 0,   0, 4'b0011, 0, 0, 0, 2);
        // Flags now 0011: N=0 Z=0 C=1 V=1
        issue(0, 1, 0, 0, COND_HI, FW_NONE, 4'b0000, 0, 1, 0, 0, 0,   1, 4'b0011, 0, 1, 0, 2);
        issue(0, 1, 0, 0, COND_GE, FW_NONE, 4'b0000, 1, 0, 0, 0, 0,   0, 4'b0011, 0, 0, 0, 3);
        issue(0, 1, 0, 0, COND_LT, FW_NONE, 4'b0000, 0, 0, 1, 0, 0,   1, 4'b0011, 0, 0, 1, 3);
        issue(0, 1, 0, 0, COND_LE, FW_CV,   4'b1100, 1, 0, 0, 0, 0,   1, 4'b0000, 1, 0, 0, 3);
        // Flags 0000 after CV-only write
        issue(0, 1, 0, 0, COND_GT, FW_NZ,   4'b1100, 1, 0, 0, 0, 0,   1, 4'b1100, 1, 0, 0, 3);
        issue(0, 1, 0, 0, COND_LS, FW_NONE, 4'b0000, 1, 0, 0, 0, 0,   1, 4'b1100, 1, 0, 0, 3);
        issue(0, 1, 0, 0, COND_NV, FW_ALL,  4'b0000, 1, 1, 1, 0, 0,   0, 4'b1100, 0, 0, 0, 4);
        // Invalid slot with a failing condition and flag write: no effect
        issue(0, 0, 0, 0, COND_NV, FW_ALL,  4'b0011, 1, 1, 1, 0, 0,   0, 4'b1100, 0, 0, 0, 4);

        // Drive the counter up to saturation, then one extra annul
        for (int i = 5; i <= 65535; i++) begin
            issue(0, 1, 0, 0, COND_NV, FW_NONE, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 0, i[CNT_W-1:0]);
        end
        issue(0, 1, 0, 0, COND_NV, FW_NONE, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1100, 0, 0, 0, 16'hFFFF);
        issue(0, 1, 0, 0, COND_NV, FW_NONE, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b1100, 0, 0, 0, 0);
        issue(0, 1, 0, 0, COND_NV, FW_NONE, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1100, 0, 0, 0, 1);
        issue(0, 1, 0, 0, COND_AL, FW_ALL,  4'b1010, 1, 0, 0, 0, 0,   1, 4'b1010, 1, 0, 0, 1);
        // Reset mid-stream beats an executing instruction
        issue(1, 1, 0, 0, COND_AL, FW_ALL,  4'b0101, 1, 1, 1, 0, 0,   1, 4'b0000, 0, 0, 0, 0);
        issue(0, 1, 1, 0, COND_MI, FW_ALL,  4'b0101, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (comb_q.size() != 0 || exp_q.size() != 0 || reg_pending) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", comb_q.size() + exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
